// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters (A = execute stage, B = address/branch unit)
// share one external combinational ALU. One operation is in flight at a time:
// accept (IDLE) -> drive the ALU for one cycle (EXEC) -> hold the registered
// result for the issuing requester (RESP) until that requester takes it.
//
// Build option: define ALU_ARB_ROUNDROBIN_EN to replace fixed A-first priority
// with a 1-bit round-robin pointer that favours the requester not granted last.
module alu_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID_A,
    output logic        REQ_READY_A,
    input  logic [31:0] REQ_X_A,
    input  logic [31:0] REQ_Y_A,
    input  logic [3:0]  REQ_CONTROL_A,
    input  logic        REQ_VALID_B,
    output logic        REQ_READY_B,
    input  logic [31:0] REQ_X_B,
    input  logic [31:0] REQ_Y_B,
    input  logic [3:0]  REQ_CONTROL_B,
    output logic        RSP_VALID_A,
    input  logic        RSP_READY_A,
    output logic        RSP_VALID_B,
    input  logic        RSP_READY_B,
    output logic [31:0] RSP_RESULTADO,
    output logic        RSP_ZERO,
    output logic [31:0] ALU_X,
    output logic [31:0] ALU_Y,
    output logic [3:0]  ALU_CONTROL,
    input  logic [31:0] ALU_RESULTADO,
    input  logic        ALU_ZERO,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] x_q, x_d;
    logic [31:0] y_q, y_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;

    logic        grant_a;
    logic        grant_b;
    logic        handshake;
    logic        owner_rsp_ready;

`ifdef ALU_ARB_ROUNDROBIN_EN
    // 0 favours A, 1 favours B when both requesters are valid
    logic        prio_q, prio_d;

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        grant_a = REQ_VALID_A & (~REQ_VALID_B | ~prio_q);
        grant_b = REQ_VALID_B & (~REQ_VALID_A | prio_q);
    end

    // After each accepted operation, point at the requester that lost out
    always_comb begin
        prio_d = prio_q;
        if (handshake) begin
            prio_d = REQ_READY_A;
        end
    end

    // Pointer register, back to favouring A on reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority grant: A always wins, B only when A is idle
    always_comb begin
        grant_a = REQ_VALID_A;
        grant_b = REQ_VALID_B & ~REQ_VALID_A;
    end
`endif

    // Accept only in IDLE and never while reset is held
    always_comb begin
        REQ_READY_A     = (state_q == IDLE) & grant_a & ~RST;
        REQ_READY_B     = (state_q == IDLE) & grant_b & ~RST;
        handshake       = REQ_READY_A | REQ_READY_B;
        owner_rsp_ready = owner_q ? RSP_READY_B : RSP_READY_A;
    end

    // Next-state, operand capture, ALU drive and response outputs
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        x_d         = x_q;
        y_d         = y_q;
        ctrl_d      = ctrl_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ALU_X       = 32'd0;
        ALU_Y       = 32'd0;
        ALU_CONTROL = 4'd0;
        RSP_VALID_A = 1'b0;
        RSP_VALID_B = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = EXEC;
                    owner_d = REQ_READY_B;
                    x_d     = REQ_READY_B ? REQ_X_B       : REQ_X_A;
                    y_d     = REQ_READY_B ? REQ_Y_B       : REQ_Y_A;
                    ctrl_d  = REQ_READY_B ? REQ_CONTROL_B : REQ_CONTROL_A;
                end
            end
            EXEC: begin
                ALU_X       = x_q;
                ALU_Y       = y_q;
                ALU_CONTROL = ctrl_q;
                result_d    = ALU_RESULTADO;
                zero_d      = ALU_ZERO;
                state_d     = RESP;
            end
            RESP: begin
                RSP_VALID_A = ~owner_q;
                RSP_VALID_B = owner_q;
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers; reset drops any operation in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            x_q      <= 32'd0;
            y_q      <= 32'd0;
            ctrl_q   <= 4'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign RSP_RESULTADO = result_q;
    assign RSP_ZERO      = zero_q;
    assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a stand-in ALU, a transaction-level model of the
// arbiter checked against the DUT every cycle, and directed scenarios with
// hand-computed literal results. Honours ALU_ARB_ROUNDROBIN_EN like the DUT.
module tb_alu_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID_A = 1'b0;
    logic        REQ_READY_A;
    logic [31:0] REQ_X_A = 32'd0;
    logic [31:0] REQ_Y_A = 32'd0;
    logic [3:0]  REQ_CONTROL_A = 4'd0;
    logic        REQ_VALID_B = 1'b0;
    logic        REQ_READY_B;
    logic [31:0] REQ_X_B = 32'd0;
    logic [31:0] REQ_Y_B = 32'd0;
    logic [3:0]  REQ_CONTROL_B = 4'd0;
    logic        RSP_VALID_A;
    logic        RSP_READY_A = 1'b0;
    logic        RSP_VALID_B;
    logic        RSP_READY_B = 1'b0;
    logic [31:0] RSP_RESULTADO;
    logic        RSP_ZERO;
    logic [31:0] ALU_X;
    logic [31:0] ALU_Y;
    logic [3:0]  ALU_CONTROL;
    logic [31:0] ALU_RESULTADO;
    logic        ALU_ZERO;
    logic        BUSY;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    alu_arbiter dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID_A(REQ_VALID_A), .REQ_READY_A(REQ_READY_A),
        .REQ_X_A(REQ_X_A), .REQ_Y_A(REQ_Y_A), .REQ_CONTROL_A(REQ_CONTROL_A),
        .REQ_VALID_B(REQ_VALID_B), .REQ_READY_B(REQ_READY_B),
        .REQ_X_B(REQ_X_B), .REQ_Y_B(REQ_Y_B), .REQ_CONTROL_B(REQ_CONTROL_B),
        .RSP_VALID_A(RSP_VALID_A), .RSP_READY_A(RSP_READY_A),
        .RSP_VALID_B(RSP_VALID_B), .RSP_READY_B(RSP_READY_B),
        .RSP_RESULTADO(RSP_RESULTADO), .RSP_ZERO(RSP_ZERO),
        .ALU_X(ALU_X), .ALU_Y(ALU_Y), .ALU_CONTROL(ALU_CONTROL),
        .ALU_RESULTADO(ALU_RESULTADO), .ALU_ZERO(ALU_ZERO),
        .BUSY(BUSY)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    // Cycle counter used to measure handshake spacing
    always @(posedge CLK) cycle <= cycle + 1;

    // ALU behaviour: ADD, SUB, shift-left; any other code yields 0
    function automatic logic [31:0] aluOp(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] c);
        case (c)
            4'b0000: aluOp = x + y;
            4'b0111: aluOp = x - y;
            4'b1000: aluOp = x << y[4:0];
            default: aluOp = 32'd0;
        endcase
    endfunction

    // Stand-in ALU attached to the DUT; ZERO is 1 when the result is nonzero
    always_comb begin
        ALU_RESULTADO = aluOp(ALU_X, ALU_Y, ALU_CONTROL);
        ALU_ZERO      = (ALU_RESULTADO != 32'd0);
    end

    // One comparison: counts it, reports actual and required on a miscompare
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an optional in-flight operation with its age in
    // cycles since acceptance (1 = on the ALU, 2 or more = awaiting pickup)
    logic        mBusy = 1'b0;
    int          mAge = 0;
    logic        mOwner = 1'b0;
    logic [31:0] mX = 32'd0;
    logic [31:0] mY = 32'd0;
    logic [3:0]  mC = 4'd0;
    logic [31:0] mRes = 32'd0;
    logic        mZero = 1'b0;
    logic        mFavB = 1'b0;

    // Which requester the rules say wins, given who is asking right now
    function automatic logic [1:0] modelGrant(input logic va, input logic vb, input logic favB);
`ifdef ALU_ARB_ROUNDROBIN_EN
        if (va && vb) modelGrant = favB ? 2'b10 : 2'b01;
        else          modelGrant = {vb, va};
`else
        modelGrant = va ? 2'b01 : {vb, 1'b0};
`endif
    endfunction

    // Advance the model one clock (or clear it on reset)
    always @(posedge CLK or posedge RST) begin
        logic [1:0] g;
        if (RST) begin
            mBusy = 1'b0; mAge = 0; mOwner = 1'b0; mRes = 32'd0; mZero = 1'b0; mFavB = 1'b0;
        end else if (!mBusy) begin
            g = modelGrant(REQ_VALID_A, REQ_VALID_B, mFavB);
            if (g != 2'b00) begin
                mBusy  = 1'b1;
                mAge   = 1;
                mOwner = g[1];
                mX     = g[1] ? REQ_X_B : REQ_X_A;
                mY     = g[1] ? REQ_Y_B : REQ_Y_A;
                mC     = g[1] ? REQ_CONTROL_B : REQ_CONTROL_A;
                mFavB  = g[0];
            end
        end else if (mAge == 1) begin
            mRes  = aluOp(mX, mY, mC);
            mZero = (mRes != 32'd0);
            mAge  = 2;
        end else if (mOwner ? RSP_READY_B : RSP_READY_A) begin
            mBusy = 1'b0;
        end
    end

    // Every falling edge: compare all DUT outputs with the model and check that
    // requesters keep a refused request valid and stable
    logic        prevRst = 1'b1;
    logic        prevVA = 1'b0, prevRA = 1'b0, prevVB = 1'b0, prevRB = 1'b0;
    logic [31:0] prevXA, prevYA, prevXB, prevYB;
    logic [3:0]  prevCA, prevCB;
    always @(negedge CLK) begin
        logic [1:0] g;
        logic       inExec;
        logic       inResp;
        g      = modelGrant(REQ_VALID_A, REQ_VALID_B, mFavB);
        inExec = mBusy && (mAge == 1);
        inResp = mBusy && (mAge >= 2);
        checkOutput("req_ready_a", {31'd0, REQ_READY_A}, {31'd0, !RST && !mBusy && g[0]});
        checkOutput("req_ready_b", {31'd0, REQ_READY_B}, {31'd0, !RST && !mBusy && g[1]});
        checkOutput("rsp_valid_a", {31'd0, RSP_VALID_A}, {31'd0, inResp && !mOwner});
        checkOutput("rsp_valid_b", {31'd0, RSP_VALID_B}, {31'd0, inResp && mOwner});
        checkOutput("busy", {31'd0, BUSY}, {31'd0, mBusy});
        checkOutput("alu_x", ALU_X, inExec ? mX : 32'd0);
        checkOutput("alu_y", ALU_Y, inExec ? mY : 32'd0);
        checkOutput("alu_control", {28'd0, ALU_CONTROL}, {28'd0, inExec ? mC : 4'd0});
        checkOutput("rsp_resultado", RSP_RESULTADO, mRes);
        checkOutput("rsp_zero", {31'd0, RSP_ZERO}, {31'd0, mZero});
        if (!RST && !prevRst && prevVA && !prevRA) begin
            checkOutput("protocol_a_valid", {31'd0, REQ_VALID_A}, 32'd1);
            checkOutput("protocol_a_ops", REQ_X_A ^ REQ_Y_A ^ {28'd0, REQ_CONTROL_A},
                        prevXA ^ prevYA ^ {28'd0, prevCA});
        end
        if (!RST && !prevRst && prevVB && !prevRB) begin
            checkOutput("protocol_b_valid", {31'd0, REQ_VALID_B}, 32'd1);
            checkOutput("protocol_b_ops", REQ_X_B ^ REQ_Y_B ^ {28'd0, REQ_CONTROL_B},
                        prevXB ^ prevYB ^ {28'd0, prevCB});
        end
        prevRst = RST;
        prevVA = REQ_VALID_A; prevRA = REQ_READY_A; prevXA = REQ_X_A; prevYA = REQ_Y_A; prevCA = REQ_CONTROL_A;
        prevVB = REQ_VALID_B; prevRB = REQ_READY_B; prevXB = REQ_X_B; prevYB = REQ_Y_B; prevCB = REQ_CONTROL_B;
    end

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one operation on a port and hold it until it is accepted
    task automatic applyStimulus(input bit port, input logic [31:0] x, input logic [31:0] y,
                                 input logic [3:0] c);
        bit accepted;
        accepted = 1'b0;
        if (port) begin
            REQ_X_B = x; REQ_Y_B = y; REQ_CONTROL_B = c; REQ_VALID_B = 1'b1;
        end else begin
            REQ_X_A = x; REQ_Y_A = y; REQ_CONTROL_A = c; REQ_VALID_A = 1'b1;
        end
        for (int i = 0; i < 30 && !accepted; i++) begin
            @(negedge CLK);
            accepted = port ? REQ_READY_B : REQ_READY_A;
            tick();
        end
        if (port) REQ_VALID_B = 1'b0;
        else      REQ_VALID_A = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) until the arbiter is idle again
    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge CLK);
            idle = !BUSY;
            tick();
        end
        if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    int          owners[$];
    logic [31:0] results[$];
    int          hsCycles[$];

    // Directed scenarios
    initial begin
        // Reset values, including READY held low while RST is high
        REQ_VALID_A = 1'b1;
        #3;
        checkOutput("reset_ready_a", {31'd0, REQ_READY_A}, 32'd0);
        checkOutput("reset_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("reset_result", RSP_RESULTADO, 32'd0);
        checkOutput("reset_alu_x", ALU_X, 32'd0);
        REQ_VALID_A = 1'b0;
        tick();
        RST = 1'b0;
        tick();

        // ADD from A with RSP_READY_A already high
        RSP_READY_A = 1'b1;
        applyStimulus(1'b0, 32'd5, 32'd3, 4'b0000);
        @(negedge CLK);
        checkOutput("add_exec_busy", {31'd0, BUSY}, 32'd1);
        checkOutput("add_exec_rsp_valid_a", {31'd0, RSP_VALID_A}, 32'd0);
        tick();
        @(negedge CLK);
        checkOutput("add_rsp_valid_a", {31'd0, RSP_VALID_A}, 32'd1);
        checkOutput("add_rsp_valid_b", {31'd0, RSP_VALID_B}, 32'd0);
        checkOutput("add_result", RSP_RESULTADO, 32'd8);
        checkOutput("add_zero", {31'd0, RSP_ZERO}, 32'd1);
        tick();
        @(negedge CLK);
        checkOutput("add_one_cycle_resp", {31'd0, BUSY}, 32'd0);
        tick();

        // SUB from B held for 4 cycles while A is waiting
        RSP_READY_B = 1'b0;
        applyStimulus(1'b1, 32'd7, 32'd7, 4'b0111);
        REQ_X_A = 32'd9; REQ_Y_A = 32'd1; REQ_CONTROL_A = 4'b0000; REQ_VALID_A = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("sub_hold_valid_b", {31'd0, RSP_VALID_B}, 32'd1);
            checkOutput("sub_hold_result", RSP_RESULTADO, 32'd0);
            checkOutput("sub_hold_zero", {31'd0, RSP_ZERO}, 32'd0);
            checkOutput("sub_hold_busy", {31'd0, BUSY}, 32'd1);
            checkOutput("sub_hold_ready_a", {31'd0, REQ_READY_A}, 32'd0);
            tick();
        end
        RSP_READY_B = 1'b1;
        applyStimulus(1'b0, 32'd9, 32'd1, 4'b0000);
        waitIdle();

        // Operands changed after the handshake are ignored
        applyStimulus(1'b0, 32'd5, 32'd3, 4'b0000);
        REQ_X_A = 32'd100;
        @(negedge CLK);
        checkOutput("late_change_alu_x", ALU_X, 32'd5);
        tick();
        @(negedge CLK);
        checkOutput("late_change_result", RSP_RESULTADO, 32'd8);
        tick();
        waitIdle();

        // Reset during RESP drops the response, then B shifts 4 left by 1
        RSP_READY_A = 1'b0;
        applyStimulus(1'b0, 32'd6, 32'd2, 4'b0111);
        tick();
        @(negedge CLK);
        checkOutput("pre_reset_rsp_valid_a", {31'd0, RSP_VALID_A}, 32'd1);
        #1 RST = 1'b1;
        #1;
        checkOutput("async_reset_rsp_valid_a", {31'd0, RSP_VALID_A}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, BUSY}, 32'd0);
        checkOutput("async_reset_result", RSP_RESULTADO, 32'd0);
        tick();
        RST = 1'b0;
        RSP_READY_A = 1'b1;
        applyStimulus(1'b1, 32'd4, 32'd1, 4'b1000);
        tick();
        @(negedge CLK);
        checkOutput("post_reset_rsp_valid_b", {31'd0, RSP_VALID_B}, 32'd1);
        checkOutput("post_reset_result", RSP_RESULTADO, 32'd8);
        tick();
        waitIdle();

        // Both requesters valid for 4 operations; each drops only once served
        REQ_X_A = 32'd1; REQ_Y_A = 32'd1; REQ_CONTROL_A = 4'b0000; REQ_VALID_A = 1'b1;
        REQ_X_B = 32'd2; REQ_Y_B = 32'd2; REQ_CONTROL_B = 4'b0000; REQ_VALID_B = 1'b1;
        for (int i = 0; i < 80 && (REQ_VALID_A || REQ_VALID_B || BUSY); i++) begin
            bit hsA, hsB;
            @(negedge CLK);
            hsA = REQ_READY_A;
            hsB = REQ_READY_B;
            if (hsA) owners.push_back(0);
            if (hsB) owners.push_back(1);
            if (RSP_VALID_A || RSP_VALID_B) results.push_back(RSP_RESULTADO);
            tick();
            if (hsA && owners.size() >= 4) REQ_VALID_A = 1'b0;
            if (hsB && owners.size() >= 4) REQ_VALID_B = 1'b0;
        end
        checkOutput("both_ops_seen", (owners.size() >= 4 && results.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (owners.size() >= 4 && results.size() >= 4) begin
`ifdef ALU_ARB_ROUNDROBIN_EN
            checkOutput("rr_owners", {owners[0][7:0], owners[1][7:0], owners[2][7:0], owners[3][7:0]}, 32'h00010001);
            checkOutput("rr_results", results[0] + results[1] * 10 + results[2] * 100 + results[3] * 1000, 32'd4242);
`else
            checkOutput("fixed_owners", {owners[0][7:0], owners[1][7:0], owners[2][7:0], owners[3][7:0]}, 32'h00000000);
            checkOutput("fixed_results", results[0] + results[1] * 10 + results[2] * 100 + results[3] * 1000, 32'd2222);
`endif
        end
        REQ_VALID_A = 1'b0;
        REQ_VALID_B = 1'b0;
        waitIdle();

        // Back-to-back from A with RSP_READY_A high: handshakes 3 cycles apart
        REQ_X_A = 32'd10; REQ_Y_A = 32'd20; REQ_CONTROL_A = 4'b0000; REQ_VALID_A = 1'b1;
        for (int i = 0; i < 40 && REQ_VALID_A; i++) begin
            bit hsA;
            @(negedge CLK);
            hsA = REQ_READY_A;
            if (hsA) hsCycles.push_back(cycle);
            tick();
            if (hsA && hsCycles.size() >= 3) REQ_VALID_A = 1'b0;
        end
        checkOutput("b2b_count", hsCycles.size(), 32'd3);
        if (hsCycles.size() >= 3) begin
            checkOutput("b2b_gap1", hsCycles[1] - hsCycles[0], 32'd3);
            checkOutput("b2b_gap2", hsCycles[2] - hsCycles[1], 32'd3);
        end
        REQ_VALID_A = 1'b0;
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single combinational ALU between two requesters: port A (execute stage) and port B (address/branch unit).
- Accepts one operation at a time over a valid/ready handshake and registers the operands.
- Drives the ALU for one cycle and registers RESULTADO/ZERO.
- Returns the response to the requester that issued the operation, holding it until that requester takes it.

## Interface
- No parameters; all widths fixed (operands 32 bits, CONTROL 4 bits).
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_VALID_A / REQ_VALID_B  in  1  requester has an operation.
- REQ_READY_A / REQ_READY_B  out  1  operation accepted this cycle when VALID & READY.
- REQ_X_A, REQ_Y_A / REQ_X_B, REQ_Y_B  in  32  operands, signed.
- REQ_CONTROL_A / REQ_CONTROL_B  in  4  ALU operation code, ALU encoding.
- RSP_VALID_A / RSP_VALID_B  out  1  response pending for that requester.
- RSP_READY_A / RSP_READY_B  in  1  requester consumes response.
- RSP_RESULTADO  out  32  registered ALU result, shared by both requesters.
- RSP_ZERO  out  1  registered ALU ZERO flag, passed unmodified (1 = result nonzero).
- ALU_X, ALU_Y  out  32  to ALU inputs.
- ALU_CONTROL  out  4  to ALU CONTROL.
- ALU_RESULTADO  in  32  from ALU.
- ALU_ZERO  in  1  from ALU.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States and transitions:
  - IDLE: wait for a request.
  - EXEC: drive the ALU.
  - RESP: hold the response.
  - IDLE -> EXEC on any handshake.
  - EXEC -> RESP always.
  - RESP -> IDLE when RSP_READY of the owner is high.
- Grant is combinational, in IDLE only.
  - One requester valid: that requester is granted.
  - Both valid: the requester with priority is granted.
  - REQ_READY_x = (state==IDLE) & grant_x. At most one READY is high per cycle; both READYs are low outside IDLE.
- On handshake:
  - REQ_X, REQ_Y and REQ_CONTROL are captured into operand registers.
  - OWNER is captured (0=A, 1=B).
  - Later changes on the request ports are ignored.
- ALU drive:
  - In EXEC, ALU_X/ALU_Y/ALU_CONTROL are driven from the operand registers.
  - At the end of EXEC, ALU_RESULTADO and ALU_ZERO are registered into RSP_RESULTADO and RSP_ZERO.
  - In IDLE and RESP, ALU_X, ALU_Y and ALU_CONTROL are 0.
- Response:
  - In RESP, RSP_VALID of OWNER is high and the other RSP_VALID is low.
  - RSP_RESULTADO and RSP_ZERO stay stable until the owner's RSP_READY is sampled high.
  - The non-owner's RSP_READY is ignored.
- Protocol rule for requesters: REQ_VALID, once raised, stays high with stable operands until accepted. The bench asserts this.
- Unknown CONTROL codes are forwarded unchanged; the ALU default produces 0.

## Timing
- Reset values:
  - State IDLE, BUSY=0.
  - REQ_READY_A=REQ_READY_B=0 while RST is high.
  - RSP_VALID_A=RSP_VALID_B=0.
  - RSP_RESULTADO=0, RSP_ZERO=0.
  - ALU_X=ALU_Y=0, ALU_CONTROL=0.
  - OWNER=0, priority pointer favours A.
- Latency:
  - Handshake in cycle n.
  - EXEC in cycle n+1.
  - RSP_VALID high from cycle n+2.
- Minimum issue interval is 3 cycles. A response consumed in cycle m allows the next handshake in m+1.
- RSP_READY already high when RESP is entered: response lasts exactly one cycle.
- RST asserted mid-operation (EXEC or RESP): the operation and any pending response are dropped, all outputs return to reset values immediately, and the pointer resets.
- Request arriving while BUSY: it waits and is not lost, because VALID is held by protocol.

## Configuration
- ALU_ARB_ROUNDROBIN_EN defined:
  - A 1-bit priority pointer toggles to favour the non-granted requester after every handshake.
  - With both valid continuously, grants alternate A, B, A, B.
- ALU_ARB_ROUNDROBIN_EN undefined:
  - Fixed priority, A always wins; no pointer register.
  - With both valid continuously, B is granted only when A is not valid.

## Test plan
- ADD from A: X=5, Y=3, CONTROL=0000, RSP_READY_A=1 -> RSP_VALID_A high 2 cycles after the handshake, RESULTADO=8, ZERO=1, RSP_VALID_B=0.
- SUB from B: X=7, Y=7, CONTROL=0111 -> RESULTADO=0, ZERO=0. RSP_READY_B held low 4 cycles -> output stable, BUSY=1, REQ_READY_A=0 throughout.
- Both valid for 4 operations (A: X=1,Y=1 ADD; B: X=2,Y=2 ADD):
  - With macro -> owners A,B,A,B, results 2,4,2,4.
  - Without macro -> owners A,A,A,A.
- Operands changed after handshake (X 5->100 during EXEC) -> result still uses 5.
- RST pulsed during RESP with RSP_READY low -> RSP_VALID drops asynchronously, state IDLE, and the next request from B (X=4,Y=1,CONTROL=1000) returns 8.
- Back-to-back: RSP_READY_A held high, A continuously valid with 3 operations -> handshakes 3 cycles apart.
